// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter slice: RAM handshake states, arbiter FSM
// states, requester classes and an index-width helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    BLOCK2 = 2'd2
  } arb_state_t;

  typedef enum logic {
    CLS_I = 1'b0,
    CLS_D = 1'b1
  } arb_class_t;

  // Index width that stays at least one bit wide for a single-core build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side bus of the memory arbiter. The arbiter takes the
// slave view; caches plus RAM (or a bench) take the master view.
interface memory_arbiter_if #(
  parameter int CPUS = 2
);
  import cpu_types_pkg::*;

  logic      [CPUS-1:0] iREN;
  word_t     [CPUS-1:0] iaddr;
  logic      [CPUS-1:0] iwait;
  word_t     [CPUS-1:0] iload;
  logic      [CPUS-1:0] dREN;
  logic      [CPUS-1:0] dWEN;
  word_t     [CPUS-1:0] daddr;
  word_t     [CPUS-1:0] dstore;
  logic      [CPUS-1:0] dwait;
  word_t     [CPUS-1:0] dload;
  logic                 ramREN;
  logic                 ramWEN;
  word_t                ramaddr;
  word_t                ramstore;
  word_t                ramload;
  ramstate_t            ramstate;
  logic                 ramerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

endinterface

// File: rtl/memory_arbiter_rr_picker.sv
// Round-robin picker: the first requester found after index `last`
// (wrapping modulo N) wins.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from farthest to nearest so the candidate closest after `last` is kept.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    for (int k = N; k >= 1; k--) begin
      valid = valid | req[(int'(last) + k) % N];
      idx   = req[(int'(last) + k) % N] ? W'((int'(last) + k) % N) : idx;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises per-core icache/dcache word requests onto the single RAM port,
// dcache first, round-robin within a class, with atomic two-word dcache blocks.
module memory_arbiter #(
  parameter int CPUS = 2
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);
  import cpu_types_pkg::*;

  localparam int              IDXW     = idx_width(CPUS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CPUS - 1);

  arb_state_t      state_r, state_nxt_s;
  arb_class_t      gclass_r, gclass_nxt_s;
  logic [IDXW-1:0] gidx_r, gidx_nxt_s;
  logic [IDXW-1:0] d_ptr_r, d_ptr_nxt_s;
  logic [IDXW-1:0] i_ptr_r, i_ptr_nxt_s;
  logic            ramerr_r, ramerr_nxt_s;
  logic [CPUS-1:0] dreq_s;
  logic            d_valid_s, i_valid_s;
  logic [IDXW-1:0] d_win_s, i_win_s;
  logic            greq_s, busy_s, access_s, to_block2_s, release_s;

  assign dreq_s     = bus.dREN | bus.dWEN;
  assign bus.ramerr = ramerr_r;

  rr_picker #(.N(CPUS), .W(IDXW)) u_d_pick (
    .req(dreq_s), .last(d_ptr_r), .valid(d_valid_s), .idx(d_win_s)
  );

  rr_picker #(.N(CPUS), .W(IDXW)) u_i_pick (
    .req(bus.iREN), .last(i_ptr_r), .valid(i_valid_s), .idx(i_win_s)
  );

  // State, grant and pointer registers; pointers start at the last core so core 0 wins first.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= IDLE;
      gclass_r <= CLS_I;
      gidx_r   <= {IDXW{1'b0}};
      d_ptr_r  <= LAST_IDX;
      i_ptr_r  <= LAST_IDX;
      ramerr_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      gclass_r <= gclass_nxt_s;
      gidx_r   <= gidx_nxt_s;
      d_ptr_r  <= d_ptr_nxt_s;
      i_ptr_r  <= i_ptr_nxt_s;
      ramerr_r <= ramerr_nxt_s;
    end
  end

  // Grant status: a dcache word at an even word address opens a two-word block.
  always_comb begin
    greq_s      = (gclass_r == CLS_D) ? dreq_s[gidx_r] : bus.iREN[gidx_r];
    busy_s      = (state_r == SERVE) || (state_r == BLOCK2);
    access_s    = busy_s && greq_s && (bus.ramstate == ACCESS);
    to_block2_s = access_s && (state_r == SERVE) && (gclass_r == CLS_D) &&
                  !bus.daddr[gidx_r][2];
    release_s   = busy_s && (!greq_s || (access_s && !to_block2_s));
  end

  // Next-state, grant capture on leaving IDLE, pointer advance on release.
  always_comb begin
    state_nxt_s  = state_r;
    gclass_nxt_s = gclass_r;
    gidx_nxt_s   = gidx_r;
    ramerr_nxt_s = ramerr_r | (busy_s && (bus.ramstate == ERROR));
    case (state_r)
      IDLE: begin
        if (d_valid_s) begin
          state_nxt_s  = SERVE;
          gclass_nxt_s = CLS_D;
          gidx_nxt_s   = d_win_s;
        end else if (i_valid_s) begin
          state_nxt_s  = SERVE;
          gclass_nxt_s = CLS_I;
          gidx_nxt_s   = i_win_s;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      SERVE: begin
        if (release_s)        state_nxt_s = IDLE;
        else if (to_block2_s) state_nxt_s = BLOCK2;
        else                  state_nxt_s = SERVE;
      end
      BLOCK2: begin
        if (release_s) state_nxt_s = IDLE;
        else           state_nxt_s = BLOCK2;
      end
      default: state_nxt_s = IDLE;
    endcase
    if (release_s && (gclass_r == CLS_D)) d_ptr_nxt_s = gidx_r;
    else                                  d_ptr_nxt_s = d_ptr_r;
    if (release_s && (gclass_r == CLS_I)) i_ptr_nxt_s = gidx_r;
    else                                  i_ptr_nxt_s = i_ptr_r;
  end

  // RAM mux and wait decode; a dropped request drives nothing onto RAM.
  always_comb begin
    bus.iwait = {CPUS{1'b1}};
    bus.dwait = {CPUS{1'b1}};
    for (int c = 0; c < CPUS; c++) begin
      bus.iload[c] = bus.ramload;
      bus.dload[c] = bus.ramload;
    end
    if (busy_s && greq_s && (gclass_r == CLS_D)) begin
      bus.ramREN   = bus.dREN[gidx_r] & ~bus.dWEN[gidx_r];
      bus.ramWEN   = bus.dWEN[gidx_r];
      bus.ramaddr  = bus.daddr[gidx_r];
      bus.ramstore = bus.dstore[gidx_r];
    end else if (busy_s && greq_s) begin
      bus.ramREN   = bus.iREN[gidx_r];
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = bus.iaddr[gidx_r];
      bus.ramstore = 32'h0000_0000;
    end else begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'h0000_0000;
      bus.ramstore = 32'h0000_0000;
    end
    bus.dwait[gidx_r] = !(access_s && (gclass_r == CLS_D));
    bus.iwait[gidx_r] = !(access_s && (gclass_r == CLS_I));
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected RAM words are queued as
// requests are issued and checked on every wait pulse.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int          CPUS     = 2;
  localparam logic [31:0] LOAD_KEY = 32'hA5A5_0000;

  typedef struct {
    bit          is_d;
    int          core;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  int   n_err = 0;
  int   n_chk = 0;
  int   cyc   = 0;
  int   lat   = 0;
  int   ram_cnt;
  bit   err_mode = 1'b0;
  exp_t sb_q[$];

  memory_arbiter_if #(.CPUS(CPUS)) bus ();
  memory_arbiter #(.CPUS(CPUS)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: ACCESS after `lat` BUSY cycles of a steady strobe.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) ram_cnt <= 0;
    else if (bus.ramstate == ACCESS || !(bus.ramREN | bus.ramWEN)) ram_cnt <= 0;
    else ram_cnt <= ram_cnt + 1;
  end

  always_comb begin
    if (err_mode) bus.ramstate = ERROR;
    else if (!(bus.ramREN | bus.ramWEN)) bus.ramstate = FREE;
    else if (ram_cnt >= lat) bus.ramstate = ACCESS;
    else bus.ramstate = BUSY;
  end

  assign bus.ramload = bus.ramaddr ^ LOAD_KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_word(input bit is_d, input int core, input bit wen,
                             input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d; e.core = core; e.wen = wen; e.addr = addr; e.data = data;
    sb_q.push_back(e);
  endtask

  // Wait-bit index: 0..1 = iwait[core], 2..3 = dwait[core].
  task automatic wait_pulse(input string tag, input int exp_which, output int at);
    logic [3:0] w;
    int which;
    which = -1;
    at    = -1;
    for (int k = 0; k < 64 && which < 0; k++) begin
      @(negedge CLK);
      w = ~{bus.dwait, bus.iwait};
      for (int j = 3; j >= 0; j--) if (w[j]) which = j;
      at = cyc;
    end
    chk(tag, 32'(which), 32'(exp_which));
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    for (int c = 0; c < CPUS; c++) begin
      bus.iaddr[c] = 32'h0; bus.daddr[c] = 32'h0; bus.dstore[c] = 32'h0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_iwait"}, 32'(bus.iwait), 32'h3);
    chk({tag, "_dwait"}, 32'(bus.dwait), 32'h3);
    chk({tag, "_ramREN"}, 32'(bus.ramREN), 32'h0);
    chk({tag, "_ramWEN"}, 32'(bus.ramWEN), 32'h0);
    chk({tag, "_ramaddr"}, bus.ramaddr, 32'h0);
    chk({tag, "_ramstore"}, bus.ramstore, 32'h0);
    chk({tag, "_ramerr"}, 32'(bus.ramerr), 32'h0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  // Monitor: every wait pulse must match the oldest queued expectation.
  exp_t        mon_e;
  logic [3:0]  mon_w, mon_x;
  logic [31:0] mon_load;
  always @(negedge CLK) begin
    mon_w = {bus.dwait, bus.iwait};
    if (nRST && mon_w != 4'hF) begin
      if (sb_q.size() == 0) begin
        chk("spurious_wait", 32'(mon_w), 32'hF);
      end else begin
        mon_e = sb_q.pop_front();
        mon_x = 4'hF;
        mon_x[(mon_e.is_d ? 2 : 0) + mon_e.core] = 1'b0;
        chk("wait_sel", 32'(mon_w), 32'(mon_x));
        chk("ramaddr", bus.ramaddr, mon_e.addr);
        chk("ramWEN", 32'(bus.ramWEN), 32'(mon_e.wen));
        chk("ramREN", 32'(bus.ramREN), 32'(!mon_e.wen));
        if (mon_e.wen) begin
          chk("ramstore", bus.ramstore, mon_e.data);
        end else begin
          mon_load = mon_e.is_d ? bus.dload[mon_e.core] : bus.iload[mon_e.core];
          chk("load", mon_load, mon_e.addr ^ LOAD_KEY);
        end
      end
    end
  end

  initial begin
    int c0, t1, t2, t3, which, core;
    int n_done[CPUS];
    logic [31:0] a_dat[2], b_dat[2];

    nRST = 1'b0;
    clear_inputs();
    #3 check_reset_outputs("in_reset");
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("idle");

    // Core0 instruction fetch, two BUSY cycles before ACCESS.
    lat = 2;
    @(posedge CLK); #1;
    c0 = cyc;
    expect_word(1'b0, 0, 1'b0, 32'h40, 32'h0);
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h40;
    @(negedge CLK);
    chk("ifetch_idle_addr", bus.ramaddr, 32'h0);
    @(negedge CLK);
    chk("ifetch_addr_n1", bus.ramaddr, 32'h40);
    chk("ifetch_ren_n1", 32'(bus.ramREN), 32'h1);
    chk("ifetch_busy_wait", 32'(bus.iwait), 32'h3);
    wait_pulse("ifetch_pulse", 0, t1);
    bus.iREN[0] = 1'b0;
    chk("ifetch_latency", 32'(t1 - c0), 32'd3);
    @(negedge CLK);
    chk("ifetch_one_cycle", 32'(bus.iwait), 32'h3);

    // dcache block beats a simultaneous icache request; no gap inside the block.
    lat = 0;
    @(posedge CLK); #1;
    expect_word(1'b1, 0, 1'b0, 32'h100, 32'h0);
    expect_word(1'b1, 0, 1'b0, 32'h104, 32'h0);
    expect_word(1'b0, 1, 1'b0, 32'h80, 32'h0);
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h100;
    bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h80;
    wait_pulse("blk_word0", 2, t1);
    bus.daddr[0] = 32'h104;
    wait_pulse("blk_word1", 2, t2);
    bus.dREN[0] = 1'b0;
    chk("blk_no_gap", 32'(t2 - t1), 32'd1);
    wait_pulse("i_after_blk", 1, t3);
    bus.iREN[1] = 1'b0;
    chk("idle_bubble", 32'(t3 - t2), 32'd2);

    // Both dcaches hammer single-word writes at 0x204; grants must alternate.
    clear_inputs();
    do_reset();
    lat = 1;
    a_dat[0] = 32'h1111_0000; a_dat[1] = 32'h1111_0001;
    b_dat[0] = 32'h2222_0000; b_dat[1] = 32'h2222_0001;
    for (int k = 0; k < 2; k++) begin
      expect_word(1'b1, 0, 1'b1, 32'h204, a_dat[k]);
      expect_word(1'b1, 1, 1'b1, 32'h204, b_dat[k]);
    end
    n_done[0] = 0; n_done[1] = 0;
    bus.dWEN = 2'b11;
    bus.daddr[0] = 32'h204; bus.daddr[1] = 32'h204;
    bus.dstore[0] = a_dat[0]; bus.dstore[1] = b_dat[0];
    for (int n = 0; n < 4; n++) begin
      wait_pulse("rr_alternate", 2 + (n % 2), t1);
      core = n % 2;
      n_done[core]++;
      if (n_done[core] == 2) bus.dWEN[core] = 1'b0;
      else if (core == 0) bus.dstore[0] = a_dat[1];
      else bus.dstore[1] = b_dat[1];
    end

    // Read+write together is a write; dropping inside BLOCK2 returns to IDLE.
    lat = 0;
    @(posedge CLK); #1;
    expect_word(1'b1, 1, 1'b1, 32'h3100, 32'hCAFE_0001);
    bus.dREN[1] = 1'b1; bus.dWEN[1] = 1'b1;
    bus.daddr[1] = 32'h3100; bus.dstore[1] = 32'hCAFE_0001;
    wait_pulse("rw_write", 3, t1);
    bus.dREN[1] = 1'b0; bus.dWEN[1] = 1'b0; bus.daddr[1] = 32'h3104;
    @(negedge CLK);
    chk("drop_ramWEN", 32'(bus.ramWEN), 32'h0);
    chk("drop_ramREN", 32'(bus.ramREN), 32'h0);
    chk("drop_dwait", 32'(bus.dwait), 32'h3);
    @(posedge CLK); #1;
    c0 = cyc;
    expect_word(1'b0, 0, 1'b0, 32'h600, 32'h0);
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h600;
    wait_pulse("after_drop", 0, t1);
    bus.iREN[0] = 1'b0;
    chk("min_latency", 32'(t1 - c0), 32'd1);

    // ERROR while serving: wait held high, ramerr sticky.
    @(posedge CLK); #1;
    err_mode = 1'b1;
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h500;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("err_wait_high", 32'(bus.iwait), 32'h3);
    end
    chk("ramerr_set", 32'(bus.ramerr), 32'h1);
    @(posedge CLK); #1;
    err_mode = 1'b0;
    expect_word(1'b0, 0, 1'b0, 32'h500, 32'h0);
    wait_pulse("err_recover", 0, t1);
    bus.iREN[0] = 1'b0;
    @(negedge CLK);
    chk("ramerr_sticky", 32'(bus.ramerr), 32'h1);

    // Asynchronous reset in the middle of a SERVE.
    lat = 10;
    @(posedge CLK); #1;
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h704;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_reset_ren", 32'(bus.ramREN), 32'h1);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("async_reset");
    clear_inputs();
    @(posedge CLK); #1;
    nRST = 1'b1;
    lat = 0;
    repeat (2) @(negedge CLK);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shared-memory arbiter directly downstream of the per-core icache and dcache blocks. It accepts word-granular read/write requests from every cache of every core and serialises them onto the single RAM port. Two-word dcache block transfers (fill, writeback, flush) are kept atomic. Final data reaches RAM through this block.

## Interface
Parameters:
- CPUS, 2: number of cores; each core has one icache and one dcache requester.

Ports:
- CLK  in  1  clock; one clock domain, rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- iREN  in  CPUS  instruction read request, per core.
- iaddr  in  CPUS x 32  instruction word address.
- iwait  out  CPUS  low only in the cycle the instruction word is returned.
- iload  out  CPUS x 32  instruction read data.
- dREN / dWEN  in  CPUS each  data read / write request.
- daddr / dstore  in  CPUS x 32 each  data address / write data.
- dwait  out  CPUS  low only in the completion cycle of the data access.
- dload  out  CPUS x 32  data read data.
- ramREN / ramWEN  out  1 each  RAM strobes.
- ramaddr / ramstore  out  32 each  RAM address / write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramerr  out  1  sticky; set when ERROR is observed while serving a request.

## Operation
- Request classes:
  - d-request of core c: dREN[c] | dWEN[c].
  - i-request of core c: iREN[c].
  - If dREN and dWEN are both high, the access is a write; ramREN is held 0.
- Priority:
  - Any pending d-request beats every i-request.
  - Within a class, round-robin: the search starts at last-granted index + 1 mod CPUS.
  - Separate pointers are kept for d and i.
  - Both pointers reset to CPUS-1, so core 0 wins first.
- Grant registers: gclass (d/i) and gidx. They are updated only on a transition out of IDLE.
- States:
  - IDLE: RAM strobes 0, ramaddr/ramstore 0.
    - If any request is pending: register the winner, go to SERVE.
  - SERVE: drive RAM from the granted requester (REN/WEN/addr/store).
    - ramstate==ACCESS: granted wait=0 this cycle.
      - If gclass=d and daddr[2]==0: go to BLOCK2, grant held.
      - Otherwise: go to IDLE and advance that class pointer to gidx.
    - Granted request deasserted: go to IDLE immediately, no RAM access, pointer still advanced.
    - BUSY/FREE/ERROR: hold, wait=1.
  - BLOCK2: same drive and completion rules as SERVE. On ACCESS go to IDLE with pointer advanced. On request drop go to IDLE.
- dload[c] and iload[c] are ramload for all c. Only the wait signals distinguish the data.
- All non-granted waits are held at 1. A request that is never granted is never lost; it stays pending.
- ramerr is cleared only by reset.

## Timing
- Reset values:
  - state IDLE.
  - all iwait/dwait 1.
  - ramREN/ramWEN 0; ramaddr/ramstore 0.
  - ramerr 0.
  - pointers CPUS-1.
- Minimum latency: request seen in IDLE at cycle n; RAM is driven in cycle n+1; wait can drop in n+1 if ramstate==ACCESS.
- Back-to-back: one IDLE bubble between independent grants. There is no bubble between the two words of a dcache block.
- Wait is low for exactly one cycle per word. Requesters change address on the edge following wait low.
- A new d-request arriving during an i-grant does not preempt it; it is picked at the next IDLE.
- In BLOCK2, higher-priority or other-core requests wait until the block completes.
- RAM signals are combinational from the grant state and requester inputs. No registered data path.
- Asynchronous reset mid-access: strobes drop immediately, state IDLE, and no partial-block memory is retained.

## Structure
- cpu_types_pkg:
  - word_t.
  - ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
  - arb_state_t {IDLE, SERVE, BLOCK2}.
  - arb_class_t {CLS_I, CLS_D}.
- Sub-module rr_picker (parameter N): inputs req[N] and last index; outputs valid and winner index. Instantiated twice, once for d and once for i.
- Top-level module: FSM, grant registers, RAM mux, wait decode.

## Test plan
- Reset, then idle: all waits 1, ramREN=ramWEN=0, ramaddr=0, ramerr=0.
- Core0 iREN, iaddr=0x40, RAM ACCESS after 2 BUSY cycles: ramaddr=0x40 from the cycle after the request; iwait[0]=0 exactly one cycle; iload[0]=ramload.
- Core0 dREN on 0x100 and core1 iREN together: dcache granted first. The block 0x100/0x104 completes with no gap (SERVE then BLOCK2). Then core1 i is served after one IDLE bubble.
- Both dcaches continuously request single-word writes at 0x204 (CPUS=2): grants alternate core0, core1, core0; each dwait pulse is matched with ramWEN=1 and ramstore equal to the granted dstore.
- Core1 writes at 0x3100 with dREN=dWEN=1: ramWEN=1, ramREN=0. Core1 drops the request in BLOCK2: state returns to IDLE with no ACCESS consumed.
- ramstate=ERROR while serving: ramerr=1 sticky and wait stays 1. Assert nRST low mid-SERVE: outputs return to reset values asynchronously.
